// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - Shared Tomasulo pipeline types: CDB broadcast and write-back request payloads
package tomasulo_pkg;

    localparam int TAG_W   = 4;
    localparam int REG_W   = 5;
    localparam int WORD_W  = 32;
    localparam int ROBID_W = 4;

    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [REG_W-1:0]   reg_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [ROBID_W-1:0] robid_t;

    typedef struct packed {
        logic   vld;
        tag_t   tag;
        reg_t   wa;
        word_t  wdata;
        robid_t robid;
    } cdb_t;

    localparam int CDB_W = $bits(cdb_t);

    typedef struct packed {
        tag_t   tag;
        reg_t   wa;
        word_t  wdata;
        robid_t robid;
    } wb_t;

    localparam int WB_W = $bits(wb_t);

    localparam int WB_REQ_N = 3;
    localparam int WB_ARITH = 0;
    localparam int WB_LOGIC = 1;
    localparam int WB_MPY   = 2;

endpackage

// File: rtl/tomasulo_cdb_arb_if.sv
// rtl/tomasulo_cdb_arb_if.sv - Execution-unit write-back requests and the registered CDB broadcast
interface tomasulo_cdb_arb_if
    import tomasulo_pkg::*;
#(
    parameter int REQ_N = WB_REQ_N
) ();

    logic                  flush;
    logic [REQ_N-1:0]      req_vld;
    wb_t  [REQ_N-1:0]      req_wb;
    logic [REQ_N-1:0]      req_rdy;
    cdb_t                  cdb;
    logic [REQ_N-1:0]      grant;
    logic                  busy;

    modport master (
        output flush,
        output req_vld,
        output req_wb,
        input  req_rdy,
        input  cdb,
        input  grant,
        input  busy
    );

    modport slave (
        input  flush,
        input  req_vld,
        input  req_wb,
        output req_rdy,
        output cdb,
        output grant,
        output busy
    );

endinterface

// File: rtl/tomasulo_rr_arb.sv
// rtl/tomasulo_rr_arb.sv - Generic round-robin arbiter: pointer register plus wrap-around search
module tomasulo_rr_arb #(
    parameter int REQ_N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REQ_N-1:0] req,
    output logic [REQ_N-1:0] gnt
);

    localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic             found;
    int               idx;

    // Search starts at ptr and wraps at REQ_N, so a non-power-of-two count never visits an index past REQ_N-1.
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < REQ_N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= REQ_N) begin
                idx = idx - REQ_N;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_nxt  = (idx == REQ_N - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/tomasulo_cdb_arb.sv
// rtl/tomasulo_cdb_arb.sv - CDB write-back arbiter: one holding entry per unit, round-robin grant, registered broadcast
module tomasulo_cdb_arb
    import tomasulo_pkg::*;
#(
    parameter int REQ_N = WB_REQ_N
) (
    input  logic              clk,
    input  logic              rst_n,
    tomasulo_cdb_arb_if.slave bus
);

    logic [REQ_N-1:0] full;
    logic [REQ_N-1:0] gnt;
    logic [REQ_N-1:0] arb_req;
    logic [REQ_N-1:0] accept;
    wb_t  [REQ_N-1:0] buf_q;
    wb_t              gnt_wb;
    cdb_t             cdb_q;
    logic [REQ_N-1:0] grant_q;

    // Masking candidates during flush keeps the pointer where it was.
    assign arb_req = full & {REQ_N{!bus.flush}};

    tomasulo_rr_arb #(
        .REQ_N (REQ_N)
    ) u_rr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (arb_req),
        .gnt   (gnt)
    );

    assign bus.req_rdy = {REQ_N{!bus.flush}} & (~full | gnt);
    assign accept      = bus.req_vld & bus.req_rdy;
    assign bus.busy    = |full;

    always_comb begin
        gnt_wb = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (gnt[i]) begin
                gnt_wb = buf_q[i];
            end
        end
    end

    // A same-cycle accept overwrites the entry only after the grant has read it into the CDB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= '0;
            buf_q <= '0;
        end else begin
            for (int i = 0; i < REQ_N; i++) begin
                if (bus.flush) begin
                    full[i] <= 1'b0;
                end else if (accept[i]) begin
                    full[i]  <= 1'b1;
                    buf_q[i] <= bus.req_wb[i];
                end else if (gnt[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_q   <= '0;
            grant_q <= '0;
        end else begin
            cdb_q.vld <= (|gnt) && !bus.flush;
            grant_q   <= bus.flush ? '0 : gnt;
            if ((|gnt) && !bus.flush) begin
                cdb_q.tag   <= gnt_wb.tag;
                cdb_q.wa    <= gnt_wb.wa;
                cdb_q.wdata <= gnt_wb.wdata;
                cdb_q.robid <= gnt_wb.robid;
            end
        end
    end

    assign bus.cdb   = cdb_q;
    assign bus.grant = grant_q;

endmodule

// File: tb/tb_tomasulo_cdb_arb.sv
// tb/tb_tomasulo_cdb_arb.sv - Directed self-checking bench for the CDB write-back arbiter
module tb_tomasulo_cdb_arb
    import tomasulo_pkg::*;
;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tomasulo_cdb_arb_if u_if ();

    tomasulo_cdb_arb u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic wb_t mk_wb(input int i, input logic [31:0] d);
        wb_t w;
        w.tag   = tag_t'(i + 1);
        w.wa    = reg_t'(i + 8);
        w.wdata = d;
        w.robid = robid_t'(i + 4);
        return w;
    endfunction

    function automatic cdb_t exp_cdb(input int i, input logic [31:0] d);
        cdb_t c;
        c.vld   = 1'b1;
        c.tag   = tag_t'(i + 1);
        c.wa    = reg_t'(i + 8);
        c.wdata = d;
        c.robid = robid_t'(i + 4);
        return c;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        u_if.flush   = 1'b0;
        u_if.req_vld = '0;
        u_if.req_wb  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_fill(input logic [2:0] mask, input logic [31:0] base);
        u_if.req_vld = mask;
        for (int i = 0; i < 3; i++) begin
            u_if.req_wb[i] = mk_wb(i, base + 32'(i));
        end
        cyc();
        u_if.req_vld = '0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (u_if.cdb !== '0) begin
            errors++;
            $display("FAIL reset_cdb got=%h exp=%h", u_if.cdb, '0);
        end
        checks++;
        if (u_if.grant !== 3'b000) begin
            errors++;
            $display("FAIL reset_grant got=%b exp=000", u_if.grant);
        end
        checks++;
        if (u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b exp=0", u_if.busy);
        end
        checks++;
        if (u_if.req_rdy !== 3'b111) begin
            errors++;
            $display("FAIL reset_rdy got=%b exp=111", u_if.req_rdy);
        end
    endtask

    task automatic test_single();
        cdb_t exp;
        exp = '{vld: 1'b1, tag: 4'd5, wa: 5'd3, wdata: 32'hDEADBEEF, robid: 4'd7};
        @(negedge clk);
        u_if.req_vld   = 3'b010;
        u_if.req_wb[1] = '{tag: 4'd5, wa: 5'd3, wdata: 32'hDEADBEEF, robid: 4'd7};
        #1;
        checks++;
        if (u_if.req_rdy[1] !== 1'b1) begin
            errors++;
            $display("FAIL single_rdy got=%b exp=1", u_if.req_rdy[1]);
        end
        cyc();
        u_if.req_vld = '0;
        checks++;
        if (u_if.cdb.vld !== 1'b0 || u_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_t1 got vld=%b busy=%b exp vld=0 busy=1", u_if.cdb.vld, u_if.busy);
        end
        cyc();
        checks++;
        if (u_if.cdb !== exp || u_if.grant !== 3'b010) begin
            errors++;
            $display("FAIL single_t2 got cdb=%h grant=%b exp cdb=%h grant=010", u_if.cdb, u_if.grant, exp);
        end
        cyc();
        checks++;
        if (u_if.cdb.vld !== 1'b0 || u_if.grant !== 3'b000) begin
            errors++;
            $display("FAIL single_t3 got vld=%b grant=%b exp vld=0 grant=000", u_if.cdb.vld, u_if.grant);
        end
    endtask

    task automatic test_round_robin();
        int ord [3];
        do_reset();
        drive_fill(3'b111, 32'h10);
        ord = '{0, 1, 2};
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (u_if.grant !== 3'(1 << ord[k]) || u_if.cdb !== exp_cdb(ord[k], 32'h10 + 32'(ord[k]))) begin
                errors++;
                $display("FAIL rr_ptr0_%0d got grant=%b cdb=%h exp grant=%b cdb=%h", k, u_if.grant, u_if.cdb,
                         3'(1 << ord[k]), exp_cdb(ord[k], 32'h10 + 32'(ord[k])));
            end
        end
        checks++;
        if (u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_ptr0_busy got=%b exp=0", u_if.busy);
        end
        drive_fill(3'b010, 32'h20);
        cyc();
        checks++;
        if (u_if.grant !== 3'b010) begin
            errors++;
            $display("FAIL rr_setptr got=%b exp=010", u_if.grant);
        end
        drive_fill(3'b111, 32'h30);
        ord = '{2, 0, 1};
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (u_if.grant !== 3'(1 << ord[k]) || u_if.cdb !== exp_cdb(ord[k], 32'h30 + 32'(ord[k]))) begin
                errors++;
                $display("FAIL rr_ptr2_%0d got grant=%b cdb=%h exp grant=%b cdb=%h", k, u_if.grant, u_if.cdb,
                         3'(1 << ord[k]), exp_cdb(ord[k], 32'h30 + 32'(ord[k])));
            end
        end
        checks++;
        if (u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_ptr2_busy got=%b exp=0", u_if.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_d;
        logic [31:0] m_d;
        logic [31:0] exp_d;
        logic [2:0]  exp_g;
        logic [2:0]  prev_rdy;
        int          got;
        do_reset();
        a_d = 32'h100;
        m_d = 32'h200;
        got = 0;
        u_if.req_vld   = 3'b101;
        u_if.req_wb[0] = mk_wb(0, a_d);
        u_if.req_wb[2] = mk_wb(2, m_d);
        #1;
        prev_rdy = u_if.req_rdy;
        for (int n = 0; n < 80 && got < 20; n++) begin
            @(negedge clk);
            if (prev_rdy[0]) a_d = a_d + 32'd1;
            if (prev_rdy[2]) m_d = m_d + 32'd1;
            if (u_if.cdb.vld === 1'b1) begin
                exp_d = (got % 2 == 0) ? 32'h100 + 32'(got / 2) : 32'h200 + 32'(got / 2);
                exp_g = (got % 2 == 0) ? 3'b001 : 3'b100;
                checks++;
                if (u_if.cdb.wdata !== exp_d || u_if.grant !== exp_g) begin
                    errors++;
                    $display("FAIL b2b_result_%0d got wdata=%h grant=%b exp wdata=%h grant=%b",
                             got, u_if.cdb.wdata, u_if.grant, exp_d, exp_g);
                end
                checks++;
                if ((prev_rdy & u_if.grant) !== u_if.grant) begin
                    errors++;
                    $display("FAIL b2b_rdy_on_grant_%0d got rdy=%b grant=%b", got, prev_rdy, u_if.grant);
                end
                got++;
            end
            u_if.req_wb[0] = mk_wb(0, a_d);
            u_if.req_wb[2] = mk_wb(2, m_d);
            #1;
            prev_rdy = u_if.req_rdy;
        end
        checks++;
        if (got != 20) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=20", got);
        end
        u_if.req_vld = '0;
    endtask

    task automatic test_flush();
        int ord [3];
        do_reset();
        drive_fill(3'b111, 32'h40);
        cyc();
        checks++;
        if (u_if.cdb.vld !== 1'b1 || u_if.grant !== 3'b001 || u_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre got vld=%b grant=%b busy=%b exp vld=1 grant=001 busy=1",
                     u_if.cdb.vld, u_if.grant, u_if.busy);
        end
        u_if.flush     = 1'b1;
        u_if.req_vld   = 3'b001;
        u_if.req_wb[0] = mk_wb(0, 32'h99);
        #1;
        checks++;
        if (u_if.req_rdy !== 3'b000) begin
            errors++;
            $display("FAIL flush_rdy got=%b exp=000", u_if.req_rdy);
        end
        cyc();
        u_if.flush   = 1'b0;
        u_if.req_vld = '0;
        checks++;
        if (u_if.cdb.vld !== 1'b0 || u_if.grant !== 3'b000 || u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_post got vld=%b grant=%b busy=%b exp vld=0 grant=000 busy=0",
                     u_if.cdb.vld, u_if.grant, u_if.busy);
        end
        drive_fill(3'b111, 32'h50);
        ord = '{1, 2, 0};
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (u_if.grant !== 3'(1 << ord[k]) || u_if.cdb !== exp_cdb(ord[k], 32'h50 + 32'(ord[k]))) begin
                errors++;
                $display("FAIL flush_order_%0d got grant=%b cdb=%h exp grant=%b cdb=%h", k, u_if.grant,
                         u_if.cdb, 3'(1 << ord[k]), exp_cdb(ord[k], 32'h50 + 32'(ord[k])));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_fill(3'b111, 32'h60);
        cyc();
        checks++;
        if (u_if.cdb.vld !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got vld=%b exp=1", u_if.cdb.vld);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (u_if.cdb !== '0 || u_if.grant !== 3'b000 || u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_clear got cdb=%h grant=%b busy=%b exp all zero", u_if.cdb, u_if.grant, u_if.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_fill(3'b111, 32'h70);
        cyc();
        checks++;
        if (u_if.grant !== 3'b001 || u_if.cdb !== exp_cdb(0, 32'h70)) begin
            errors++;
            $display("FAIL areset_first got grant=%b cdb=%h exp grant=001 cdb=%h", u_if.grant, u_if.cdb,
                     exp_cdb(0, 32'h70));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
